i2c_slave_ctrl: RTL and testbench
=================================

Name: i2c_slave_ctrl

Overview:
- Transaction-level I2C slave controller that sequences the bit/byte shifting of a single slave port.
- Detects START, repeated START and STOP; receives and matches the 7-bit address; generates the slave ACKs.
- Moves data bytes between the bus and a simple byte-stream user interface: rx_* for master writes, tx_* for master reads.
- Sits between the pad-level scl/sda signals and the register file / FIFO logic of the slave.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this slave responds to.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- scl_i  input  1  I2C clock from pad, asynchronous.
- sda_i  input  1  I2C data from pad, asynchronous.
- sda_o  output  1  open-drain data drive: 0 = pull low, 1 = release.
- rx_data  output  8  last byte received from master; held until next rx_valid.
- rx_valid  output  1  one-cycle pulse: rx_data updated.
- tx_req  output  1  one-cycle pulse: user must present next byte on tx_data.
- tx_data  input  8  byte to transmit; sampled at first scl fall after tx_req.
- start_det  output  1  one-cycle pulse on START or repeated START.
- stop_det  output  1  one-cycle pulse on STOP.
- addr_match  output  1  one-cycle pulse when the received address equals SLAVE_ADDR.
- rw  output  1  R/W bit of the current transaction (1 = master read); valid after addr_match.
- nack_det  output  1  one-cycle pulse when the master NACKs a transmitted byte.
- busy  output  1  high from address match until STOP or mismatch.

Behaviour:
- Input sync: scl_i and sda_i each pass a 2-flop synchronizer, then a history register.
- scl_rise / scl_fall and sda edges are computed from synchronized vs history values.
- Bus timing requirement: SCL high and low periods ≥ 8 clk.
- START: sda falls while scl high. STOP: sda rises while scl high. Both are checked before scl edges and override any state.
- START: bit counter cleared, sda_o released next cycle, state → ADDR, start_det pulse.
- STOP: state → IDLE, sda_o = 1, busy = 0, stop_det pulse.
- Sampling: data is sampled on scl_rise, MSB first.
- Driving: sda_o is registered and changes only in the cycle scl_fall is detected, i.e. 3 clk after the pin low is first sampled.
- 3-bit bit counter; wraps 7 → 0 at each byte boundary.
- States:
  - IDLE: sda_o = 1; wait for START.
  - ADDR: shift 8 bits. After the 8th rising edge:
    - addr[7:1] == SLAVE_ADDR → latch rw, addr_match pulse, busy = 1, → ADDR_ACK.
    - else → WAIT_STOP, sda_o stays 1.
  - ADDR_ACK: at the next scl_fall, sda_o = 0. At the following scl_fall:
    - rw = 0 → release sda_o, → RX_DATA.
    - rw = 1 → load tx_data into shift register, drive bit7, → TX_DATA.
    - tx_req pulses in the cycle of the ACK-bit scl_rise (rw = 1 only).
  - RX_DATA: shift 8 bits. On the 8th scl_rise: rx_data updated and rx_valid pulses in the same cycle, → RX_ACK.
  - RX_ACK: sda_o = 0 at the next scl_fall; released at the following scl_fall, → RX_DATA. Every received byte is ACKed.
  - TX_DATA: on each scl_fall, drive the next bit. After bit0 has been held and the next scl_fall arrives, release sda_o, → TX_ACK.
  - TX_ACK: sample sda on scl_rise.
    - 0 (ACK) → tx_req pulse that cycle; at the next scl_fall load tx_data, drive bit7, → TX_DATA.
    - 1 (NACK) → nack_det pulse, → WAIT_STOP.
  - WAIT_STOP: sda_o = 1, ignore scl; only START/STOP exit.
- Simultaneous events: START/STOP detection has priority over any scl edge in the same cycle. START detected in the same cycle as a STOP cannot occur; if both are seen, STOP wins.
- Reset (rst_n = 0 at any clk edge, mid-byte included) forces:
  - state IDLE, sda_o = 1, counter = 0, shift register = 0, rx_data = 0, rw = 0;
  - all pulse outputs and busy = 0.
- tx_data is not captured outside the defined load points.

Test Plan:
- Write: START, addr 0x50 + W, data 0xA5, 0x3C, STOP → addr_match = 1, rw = 0; sda_o low during 3 ACK bits; rx_valid twice with 0xA5 then 0x3C; stop_det; busy drops.
- Mismatch: START, addr 0x51 + W, byte 0xFF, STOP → no addr_match; sda_o stays 1 throughout, including the ACK slots; no rx_valid.
- Read: START, 0x50 + R, tx_data 0x81 then 0x7E, master ACK then NACK, STOP → bus shows 0x81, 0x7E; tx_req twice; nack_det once; WAIT_STOP until STOP.
- Repeated START: write 0x50 + W, byte 0x12, then Sr, 0x50 + R → second addr_match with rw = 1; counter restarted; first tx bit correct.
- STOP mid-byte: STOP after 4 bits of a received byte → no rx_valid; state IDLE; sda_o = 1. Next full transaction passes.
- Reset mid-TX: assert rst_n = 0 for 1 clk while sda_o = 0 → sda_o = 1 the next cycle; all outputs at reset values; ignores bus until the next START.

Source files
------------

// File: rtl/i2c_slave_ctrl.sv
// I2C slave transaction controller: START/STOP detection, 7-bit address match,
// slave ACK generation and byte shifting between the bus and a byte-stream interface.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       start_det,
  output logic       stop_det,
  output logic       addr_match,
  output logic       rw,
  output logic       nack_det,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StRxData, StRxAck, StTxData, StTxAck, StWaitStop
  } state_e;

  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_q, sda_d;
  logic       ack_q, ack_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       start_q, start_d, stop_q, stop_d, match_q, match_d;
  logic       rxv_q, rxv_d, txreq_q, txreq_d, nack_q, nack_d;

  logic       scl_rise, scl_fall, sda_rise, sda_fall, start_cond, stop_cond;
  logic [7:0] byte_in;

  // Idle bus level is high, so reset the synchronizers to 1 to avoid false edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {scl_s1, scl_s2, scl_h} <= 3'b111;
      {sda_s1, sda_s2, sda_h} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_h} <= {scl_i, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_h} <= {sda_i, sda_s1, sda_s2};
    end
  end

  assign scl_rise   = scl_s2 & ~scl_h;
  assign scl_fall   = ~scl_s2 & scl_h;
  assign sda_rise   = sda_s2 & ~sda_h;
  assign sda_fall   = ~sda_s2 & sda_h;
  assign start_cond = sda_fall & scl_s2 & scl_h;
  assign stop_cond  = sda_rise & scl_s2 & scl_h;
  assign byte_in    = {shreg_q[6:0], sda_s2};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    rx_data_d = rx_data_q;
    sda_d     = sda_q;
    ack_d     = ack_q;
    rw_d      = rw_q;
    busy_d    = busy_q;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    match_d   = 1'b0;
    rxv_d     = 1'b0;
    txreq_d   = 1'b0;
    nack_d    = 1'b0;

    if (stop_cond) begin
      state_d = StIdle;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
      stop_d  = 1'b1;
      cnt_d   = 3'd0;
      ack_d   = 1'b0;
    end else if (start_cond) begin
      state_d = StAddr;
      sda_d   = 1'b1;
      start_d = 1'b1;
      cnt_d   = 3'd0;
      ack_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StWaitStop: sda_d = 1'b1;
        StAddr: begin
          if (scl_rise) begin
            shreg_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                rw_d    = byte_in[0];
                match_d = 1'b1;
                busy_d  = 1'b1;
                ack_d   = 1'b0;
                state_d = StAddrAck;
              end else begin
                busy_d  = 1'b0;
                state_d = StWaitStop;
              end
            end
          end
        end
        StAddrAck: begin
          // ack_q marks that the ACK bit is on the bus; the next fall ends it.
          if (scl_rise && ack_q && rw_q) txreq_d = 1'b1;
          if (scl_fall) begin
            if (!ack_q) begin
              sda_d = 1'b0;
              ack_d = 1'b1;
            end else begin
              ack_d = 1'b0;
              cnt_d = 3'd0;
              if (rw_q) begin
                shreg_d = tx_data;
                sda_d   = tx_data[7];
                state_d = StTxData;
              end else begin
                sda_d   = 1'b1;
                state_d = StRxData;
              end
            end
          end
        end
        StRxData: begin
          if (scl_rise) begin
            shreg_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d = byte_in;
              rxv_d     = 1'b1;
              ack_d     = 1'b0;
              state_d   = StRxAck;
            end
          end
        end
        StRxAck: begin
          if (scl_fall) begin
            if (!ack_q) begin
              sda_d = 1'b0;
              ack_d = 1'b1;
            end else begin
              sda_d   = 1'b1;
              ack_d   = 1'b0;
              cnt_d   = 3'd0;
              state_d = StRxData;
            end
          end
        end
        StTxData: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              sda_d   = 1'b1;
              cnt_d   = 3'd0;
              ack_d   = 1'b0;
              state_d = StTxAck;
            end else begin
              shreg_d = {shreg_q[6:0], 1'b0};
              sda_d   = shreg_q[6];
              cnt_d   = cnt_q + 3'd1;
            end
          end
        end
        StTxAck: begin
          if (scl_rise) begin
            if (!sda_s2) begin
              txreq_d = 1'b1;
              ack_d   = 1'b1;
            end else begin
              nack_d  = 1'b1;
              sda_d   = 1'b1;
              state_d = StWaitStop;
            end
          end else if (scl_fall && ack_q) begin
            shreg_d = tx_data;
            sda_d   = tx_data[7];
            cnt_d   = 3'd0;
            ack_d   = 1'b0;
            state_d = StTxData;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      shreg_q   <= 8'd0;
      rx_data_q <= 8'd0;
      sda_q     <= 1'b1;
      ack_q     <= 1'b0;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      match_q   <= 1'b0;
      rxv_q     <= 1'b0;
      txreq_q   <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      rx_data_q <= rx_data_d;
      sda_q     <= sda_d;
      ack_q     <= ack_d;
      rw_q      <= rw_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      match_q   <= match_d;
      rxv_q     <= rxv_d;
      txreq_q   <= txreq_d;
      nack_q    <= nack_d;
    end
  end

  assign sda_o      = sda_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rxv_q;
  assign tx_req     = txreq_q;
  assign start_det  = start_q;
  assign stop_det   = stop_q;
  assign addr_match = match_q;
  assign rw         = rw_q;
  assign nack_det   = nack_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: a bit-level I2C master model drives the bus, received
// bytes are scoreboarded against a queue of expected data.
module tb_i2c_slave_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, scl_m, sda_m, sda_line;
  logic [7:0] tx_data;
  logic       sda_o, rx_valid, tx_req, start_det, stop_det, addr_match, rw, nack_det, busy;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull low.
  assign sda_line = sda_m & sda_o;

  i2c_slave_ctrl #(.SLAVE_ADDR(7'h50)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_m),
    .sda_i      (sda_line),
    .sda_o      (sda_o),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_req     (tx_req),
    .tx_data    (tx_data),
    .start_det  (start_det),
    .stop_det   (stop_det),
    .addr_match (addr_match),
    .rw         (rw),
    .nack_det   (nack_det),
    .busy       (busy)
  );

  int errors = 0;
  int checks = 0;

  int n_start = 0, n_stop = 0, n_match = 0, n_rxv = 0, n_txreq = 0, n_nack = 0, n_low = 0;
  logic [7:0] got_rx [64];

  always @(negedge clk) begin
    if (rst_n) begin
      if (start_det)  n_start <= n_start + 1;
      if (stop_det)   n_stop  <= n_stop + 1;
      if (addr_match) n_match <= n_match + 1;
      if (tx_req)     n_txreq <= n_txreq + 1;
      if (nack_det)   n_nack  <= n_nack + 1;
      if (!sda_o)     n_low   <= n_low + 1;
      if (rx_valid) begin
        got_rx[n_rxv[5:0]] <= rx_data;
        n_rxv <= n_rxv + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    cyc(4); sda_m = b;
    cyc(5); scl_m = 1'b1;
    cyc(5); r = sda_line;
    cyc(5); scl_m = 1'b0;
  endtask

  task automatic do_start();
    if (!scl_m) begin
      cyc(4); sda_m = 1'b1;
      cyc(5); scl_m = 1'b1;
      cyc(10);
    end
    sda_m = 1'b0;
    cyc(10); scl_m = 1'b0;
  endtask

  task automatic do_stop();
    cyc(4); sda_m = 1'b0;
    cyc(5); scl_m = 1'b1;
    cyc(10); sda_m = 1'b1;
    cyc(10);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], r);
    xfer_bit(1'b1, r);
    ack = ~r;
  endtask

  // tx_data is scrambled mid-byte to catch loads outside the defined load points.
  task automatic read_byte(input logic [7:0] next_tx, input logic m_ack,
                           output logic [7:0] d);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      xfer_bit(1'b1, r);
      d = {d[6:0], r};
      if (i == 0) tx_data = 8'h00;
    end
    tx_data = next_tx;
    xfer_bit(~m_ack, r);
  endtask

  logic [7:0] exp_rx [$];
  int rd_idx = 0;

  task automatic drain_rx();
    logic [7:0] e;
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      chk("rx_data", {24'd0, got_rx[rd_idx[5:0]]}, {24'd0, e});
      rd_idx++;
    end
    chk("rx_valid_count", n_rxv, rd_idx);
  endtask

  typedef struct {
    logic [6:0] addr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       match;
  } wvec_t;

  wvec_t wv [4];

  initial begin
    logic       ack, r;
    logic [7:0] d;
    int b_start, b_stop, b_match, b_rxv, b_txreq, b_nack, b_low;

    wv[0] = '{addr: 7'h50, d0: 8'hA5, d1: 8'h3C, match: 1'b1};
    wv[1] = '{addr: 7'h51, d0: 8'hFF, d1: 8'h00, match: 1'b0};
    wv[2] = '{addr: 7'h50, d0: 8'h00, d1: 8'hFF, match: 1'b1};
    wv[3] = '{addr: 7'h28, d0: 8'h5A, d1: 8'h00, match: 1'b0};

    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
    cyc(5);
    chk("reset_sda_o", sda_o, 1);
    chk("reset_flags", {start_det, stop_det, addr_match, rx_valid, tx_req, nack_det, busy, rw}, 0);
    chk("reset_rx_data", rx_data, 0);
    rst_n = 1'b1;
    cyc(5);

    // Write / mismatch vectors
    for (int v = 0; v < 4; v++) begin
      b_start = n_start; b_stop = n_stop; b_match = n_match; b_rxv = n_rxv; b_low = n_low;
      do_start();
      write_byte({wv[v].addr, 1'b0}, ack);
      chk("addr_ack", ack, wv[v].match);
      chk("busy_after_addr", busy, wv[v].match);
      if (wv[v].match) begin
        chk("rw_write", rw, 0);
        exp_rx.push_back(wv[v].d0);
        write_byte(wv[v].d0, ack);
        chk("data0_ack", ack, 1);
        exp_rx.push_back(wv[v].d1);
        write_byte(wv[v].d1, ack);
        chk("data1_ack", ack, 1);
      end else begin
        write_byte(wv[v].d0, ack);
        chk("nomatch_data_ack", ack, 0);
      end
      do_stop();
      chk("start_count", n_start - b_start, 1);
      chk("stop_count", n_stop - b_stop, 1);
      chk("match_count", n_match - b_match, wv[v].match);
      chk("rxv_count", n_rxv - b_rxv, wv[v].match ? 2 : 0);
      chk("busy_after_stop", busy, 0);
      if (!wv[v].match) chk("nomatch_sda_low", n_low - b_low, 0);
      drain_rx();
    end

    // Read: 0x81 acked, 0x7E nacked
    b_txreq = n_txreq; b_nack = n_nack; b_stop = n_stop;
    tx_data = 8'h81;
    do_start();
    write_byte({7'h50, 1'b1}, ack);
    chk("read_addr_ack", ack, 1);
    chk("read_rw", rw, 1);
    chk("read_busy", busy, 1);
    read_byte(8'h7E, 1'b1, d);
    chk("read_byte0", d, 8'h81);
    read_byte(8'hFF, 1'b0, d);
    chk("read_byte1", d, 8'h7E);
    chk("tx_req_count", n_txreq - b_txreq, 2);
    chk("nack_count", n_nack - b_nack, 1);
    xfer_bit(1'b1, r);
    chk("wait_stop_released", r, 1);
    chk("wait_stop_busy", busy, 1);
    do_stop();
    chk("read_stop", n_stop - b_stop, 1);
    chk("read_busy_end", busy, 0);

    // Repeated START: write one byte, then Sr into a read
    b_start = n_start; b_match = n_match;
    do_start();
    write_byte({7'h50, 1'b0}, ack);
    exp_rx.push_back(8'h12);
    write_byte(8'h12, ack);
    chk("sr_write_ack", ack, 1);
    tx_data = 8'hB7;
    do_start();
    write_byte({7'h50, 1'b1}, ack);
    chk("sr_addr_ack", ack, 1);
    chk("sr_rw", rw, 1);
    chk("sr_match_count", n_match - b_match, 2);
    chk("sr_start_count", n_start - b_start, 2);
    read_byte(8'hFF, 1'b0, d);
    chk("sr_read_byte", d, 8'hB7);
    do_stop();
    drain_rx();

    // STOP after 4 data bits
    b_rxv = n_rxv; b_stop = n_stop;
    do_start();
    write_byte({7'h50, 1'b0}, ack);
    for (int i = 0; i < 4; i++) xfer_bit(i[0], r);
    do_stop();
    chk("midbyte_no_rxv", n_rxv - b_rxv, 0);
    chk("midbyte_stop", n_stop - b_stop, 1);
    chk("midbyte_sda_o", sda_o, 1);
    chk("midbyte_busy", busy, 0);
    do_start();
    write_byte({7'h50, 1'b0}, ack);
    exp_rx.push_back(8'h99);
    write_byte(8'h99, ack);
    chk("after_midbyte_ack", ack, 1);
    do_stop();
    drain_rx();

    // Reset while the slave pulls sda low during a read
    tx_data = 8'h3C;
    do_start();
    write_byte({7'h50, 1'b1}, ack);
    cyc(6);
    chk("tx_bit7_low", sda_o, 0);
    rst_n = 1'b0;
    cyc(1);
    chk("rst_sda_o", sda_o, 1);
    chk("rst_flags", {start_det, stop_det, addr_match, rx_valid, tx_req, nack_det, busy, rw}, 0);
    chk("rst_rx_data", rx_data, 0);
    rst_n = 1'b1;
    b_start = n_start; b_match = n_match; b_low = n_low;
    for (int i = 0; i < 9; i++) xfer_bit(1'b1, r);
    chk("post_rst_no_low", n_low - b_low, 0);
    chk("post_rst_no_start", n_start - b_start, 0);
    do_start();
    write_byte({7'h50, 1'b0}, ack);
    chk("post_rst_addr_ack", ack, 1);
    exp_rx.push_back(8'h5A);
    write_byte(8'h5A, ack);
    do_stop();
    chk("post_rst_match", n_match - b_match, 1);
    drain_rx();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
